// File: rtl/pmu_power_seq.sv
// AFE power sequencer: steps bandgap, LDO, ADC interface and timing generator on/off in order.
// Each step dwells DLY+1 cycles; a power-good fault drops straight to OFF and latches. No backpressure.
module pmu_power_seq #(
   parameter int SETTLE_W = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                pwr_req,
   input  logic [SETTLE_W-1:0] bg_dly,
   input  logic [SETTLE_W-1:0] ldo_dly,
   input  logic [SETTLE_W-1:0] adc_dly,
   input  logic                pg_fail,
   input  logic                flt_clr,
   output logic                bg_en,
   output logic                ldo_en,
   output logic                adc_en,
   output logic                tg_en,
   output logic                pwr_rdy,
   output logic                busy,
   output logic                flt_sticky,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_UP_BG  = 3'd1,
      S_UP_LDO = 3'd2,
      S_UP_ADC = 3'd3,
      S_RUN    = 3'd4,
      S_DN_ADC = 3'd5,
      S_DN_LDO = 3'd6,
      S_DN_BG  = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic                flt_q, flt_d;
   logic                fault;
   logic                dwell_done;

   assign fault      = pg_fail && (state_q != S_OFF);
   assign dwell_done = (cnt_q == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flt_q   <= flt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (fault) begin
         state_d = S_OFF;
      end else begin
         case (state_q)
            S_OFF:    if (pwr_req && !flt_q) state_d = S_UP_BG;
            S_UP_BG:  if (!pwr_req)          state_d = S_DN_BG;
                      else if (dwell_done)   state_d = S_UP_LDO;
            S_UP_LDO: if (!pwr_req)          state_d = S_DN_LDO;
                      else if (dwell_done)   state_d = S_UP_ADC;
            S_UP_ADC: if (!pwr_req)          state_d = S_DN_ADC;
                      else if (dwell_done)   state_d = S_RUN;
            S_RUN:    if (!pwr_req)          state_d = S_DN_ADC;
            S_DN_ADC: if (dwell_done)        state_d = S_DN_LDO;
            S_DN_LDO: if (dwell_done)        state_d = S_DN_BG;
            S_DN_BG:  if (dwell_done)        state_d = S_OFF;
            default:                         state_d = S_OFF;
         endcase
      end
   end

   // Every state change reloads the dwell with the target's delay, so aborts restart the step cleanly.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         case (state_d)
            S_UP_BG,  S_DN_BG:  cnt_d = bg_dly;
            S_UP_LDO, S_DN_LDO: cnt_d = ldo_dly;
            S_UP_ADC, S_DN_ADC: cnt_d = adc_dly;
            default:            cnt_d = '0;
         endcase
      end else if (!dwell_done) begin
         cnt_d = cnt_q - SETTLE_W'(1);
      end
   end

   // Set beats clear when both arrive together.
   always_comb begin
      flt_d = flt_q;
      if (flt_clr) flt_d = 1'b0;
      if (fault)   flt_d = 1'b1;
   end

   always_comb begin
      bg_en   = 1'b0;
      ldo_en  = 1'b0;
      adc_en  = 1'b0;
      tg_en   = 1'b0;
      pwr_rdy = 1'b0;
      busy    = 1'b0;
      case (state_q)
         S_UP_BG, S_DN_BG: begin
            bg_en = 1'b1;
            busy  = 1'b1;
         end
         S_UP_LDO, S_DN_LDO: begin
            bg_en  = 1'b1;
            ldo_en = 1'b1;
            busy   = 1'b1;
         end
         S_UP_ADC, S_DN_ADC: begin
            bg_en  = 1'b1;
            ldo_en = 1'b1;
            adc_en = 1'b1;
            busy   = 1'b1;
         end
         S_RUN: begin
            bg_en   = 1'b1;
            ldo_en  = 1'b1;
            adc_en  = 1'b1;
            tg_en   = 1'b1;
            pwr_rdy = 1'b1;
         end
         default: ;
      endcase
   end

   assign flt_sticky = flt_q;
   assign state      = state_q;

endmodule

// File: doc/pmu_power_seq.md
# pmu_power_seq

Power-up/power-down sequencer for the analog front end. It steps the bandgap, LDO, AD interface and timing generator enables on and off in a fixed order, with a programmable settle time per step. Request and delay inputs come from the I2C-mapped register bank. A power-good fault forces an immediate shutdown, which stays latched until software clears it.

## Interface
- SETTLE_W, 8, width of each settle-delay field and of the internal dwell counter
- CLK  in  1  system clock; all logic on rising edge
- RSTN  in  1  asynchronous active-low reset
- PWR_REQ  in  1  level power request from the register bank (CLK domain)
- BG_DLY  in  SETTLE_W  bandgap settle delay
- LDO_DLY  in  SETTLE_W  LDO settle delay
- ADC_DLY  in  SETTLE_W  ADC settle delay
- PG_FAIL  in  1  power-good failure (CLK domain, level)
- FLT_CLR  in  1  one-cycle fault-clear strobe
- BG_EN  out  1  bandgap enable
- LDO_EN  out  1  LDO enable
- ADC_EN  out  1  AD interface enable
- TG_EN  out  1  timing generator enable
- PWR_RDY  out  1  high only in RUN
- BUSY  out  1  high in any UP_*/DN_* state
- FLT_STICKY  out  1  latched fault flag
- STATE  out  3  current state encoding, for debug and assertions

## Operation
- States and encodings: OFF=0, UP_BG=1, UP_LDO=2, UP_ADC=3, RUN=4, DN_ADC=5, DN_LDO=6, DN_BG=7.
- All outputs are decoded from registered state and registered flags. No combinational path runs from inputs to outputs.
- Enables by state:
  - OFF: none.
  - UP_BG and DN_BG: BG_EN.
  - UP_LDO and DN_LDO: BG_EN and LDO_EN.
  - UP_ADC and DN_ADC: BG_EN, LDO_EN and ADC_EN.
  - RUN: all four enables.
- TG_EN is 1 only in RUN.
- Dwell counter:
  - On entry to any UP_*/DN_* state, the counter loads that state's delay (*_DLY sampled on the entry edge). Later changes to *_DLY do not affect the current step.
  - The counter decrements each cycle and the state advances on the edge where counter==0. Dwell is therefore DLY+1 cycles; DLY=0 gives a 1-cycle dwell.
- Transitions (priority order):
  1. PG_FAIL=1 in any state other than OFF: next state OFF and FLT_STICKY←1. This also applies in RUN, with no down-sequence.
  2. OFF: go to UP_BG when PWR_REQ=1 and FLT_STICKY=0; otherwise stay.
  3. UP_BG→UP_LDO→UP_ADC→RUN on dwell expiry while PWR_REQ=1.
  4. Abort on PWR_REQ=0 during an up-step, checked every cycle: UP_BG→DN_BG, UP_LDO→DN_LDO, UP_ADC→DN_ADC. The counter reloads with the target state's delay.
  5. RUN: go to DN_ADC when PWR_REQ=0.
  6. DN_ADC→DN_LDO→DN_BG→OFF on dwell expiry. PWR_REQ is ignored here: a down-sequence always completes to OFF, and a re-request restarts from OFF (minimum 1 cycle in OFF).
- FLT_STICKY:
  - Set on the PG_FAIL event; cleared by FLT_CLR.
  - If FLT_CLR and PG_FAIL are high in the same cycle, set wins.
  - PG_FAIL while in OFF does not set the flag.
- Counter arithmetic is unsigned, SETTLE_W bits. The counter never underflows because it is reloaded on every state entry.

## Timing
- Reset (RSTN=0, asynchronous): STATE=OFF, counter=0, FLT_STICKY=0, and all enables, PWR_RDY and BUSY are 0. These values hold until the first rising CLK edge after RSTN deasserts.
- Reset asserted mid-sequence drops all enables immediately, without waiting for CLK.
- Let e0 be the first edge that samples PWR_REQ=1 in OFF:
  - Up latency: UP_BG after e0, and RUN after edge e(BG_DLY+LDO_DLY+ADC_DLY+3).
  - Down latency is symmetric: from the edge sampling PWR_REQ=0 in RUN, OFF is reached ADC_DLY+LDO_DLY+BG_DLY+3 edges later.
- Fault latency: PG_FAIL sampled high at edge n gives OFF, all enables 0 and FLT_STICKY=1 after edge n.
- Ordering invariants, checkable by the TG and PMU assertion shells:
  - TG_EN implies ADC_EN; ADC_EN implies LDO_EN; LDO_EN implies BG_EN.
  - TG_EN falls at least ADC_DLY+1 cycles before ADC_EN falls, except on fault or reset.

## Test plan
- Power-up, with BG_DLY=3, LDO_DLY=5, ADC_DLY=2 and PWR_REQ raised and sampled at e0:
  - BG_EN after e0, LDO_EN after e4, ADC_EN after e10.
  - TG_EN and PWR_RDY after e13; BUSY is 1 from e0 to e13.
- Power-down, same delays, PWR_REQ dropped and sampled at edge d0 in RUN:
  - TG_EN=0 after d0, ADC_EN=0 after d3, LDO_EN=0 after d9.
  - BG_EN=0 and STATE=OFF after d13.
- Abort and re-request, same delays:
  - Drop PWR_REQ at e6 (in UP_LDO): DN_LDO after e6, DN_BG after e12, OFF after e16.
  - Re-raise PWR_REQ at e8: it is ignored until OFF, then UP_BG follows one edge after OFF.
- Fault, with PG_FAIL=1 for one cycle in RUN:
  - All outputs 0 and FLT_STICKY=1 after that edge.
  - PWR_REQ held at 1 does not restart the sequence.
  - FLT_CLR pulse: UP_BG on the edge after FLT_STICKY clears.
- Simultaneous FLT_CLR=1 and PG_FAIL=1 in UP_ADC → OFF with FLT_STICKY=1.
- Zero delays (all DLY=0): RUN reached 3 edges after e0. Then assert RSTN=0 asynchronously mid-cycle → all enables 0 before the next CLK edge.
